hec_arb: RTL and testbench

Round-robin arbiter that shares one combinational HEC (CRC-8, x^8+x^2+x+1, coset 0x55) calculator among NREQ requesters. Each requester submits a 32-bit ATM cell header in generate mode (return the HEC) or check mode (compare against a supplied HEC and flag mismatch). The block drives the calculator's 32-bit input, registers its 8-bit result into a single-entry response stage with valid/ready handshake, and keeps a saturating HEC-error counter. It sits between the per-port UTOPIA receive/transmit header paths and the shared HEC datapath.

---
 rtl/hec_arb.sv | 88 ++++++++
 tb/tb_hec_arb.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hec_arb.sv
// Round-robin arbiter sharing one combinational HEC calculator among NREQ requesters.
// The granted header drives hec_in; the returned HEC is registered into a one-deep response stage.
module hec_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*32-1:0]   req_hdr,
  input  logic [NREQ*8-1:0]    req_hec,
  input  logic [NREQ-1:0]      req_chk,
  output logic [NREQ-1:0]      req_ready,
  output logic [31:0]          hec_in,
  input  logic [7:0]           hec_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [7:0]           rsp_hec,
  output logic                 rsp_err,
  output logic [15:0]          err_cnt
);

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [7:0]     hec;
    logic           err;
  } rsp_t;

  rsp_t           rsp_q, rsp_d;
  logic           rsp_valid_q;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [15:0]    err_cnt_q;

  logic           free;
  logic           gnt_vld;
  logic [IDW-1:0] gnt_id;
  logic [IDW:0]   sum;

  always_comb begin
    free    = ~rsp_valid_q | rsp_ready;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    sum     = '0;
    // Walk offsets from farthest to nearest so the nearest valid requester wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_q} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      if (req_valid[sum[IDW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_id  = sum[IDW-1:0];
      end
    end
    // Nothing may be granted while reset is held, even though the slot looks free.
    gnt_vld = gnt_vld & free & rst_n;

    req_ready = gnt_vld ? ({{(NREQ-1){1'b0}}, 1'b1} << gnt_id) : '0;
    hec_in    = gnt_vld ? req_hdr[32*gnt_id +: 32] : 32'h0;

    ptr_d     = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
    rsp_d.id  = gnt_id;
    rsp_d.hec = hec_out;
    rsp_d.err = req_chk[gnt_id] & (hec_out != req_hec[8*gnt_id +: 8]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
      ptr_q       <= '0;
      err_cnt_q   <= '0;
    end else if (gnt_vld) begin
      rsp_valid_q <= 1'b1;
      rsp_q       <= rsp_d;
      ptr_q       <= ptr_d;
      if (rsp_d.err && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
    end else if (rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_q.id;
  assign rsp_hec   = rsp_q.hec;
  assign rsp_err   = rsp_q.err;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_hec_arb.sv
// Bench for hec_arb: behavioural CRC calculator, circular-search grant model feeding a scoreboard,
// and an independent monitor that checks every presented response against the queue.
module tb_hec_arb;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                clk = 0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*32-1:0]  req_hdr;
  logic [NREQ*8-1:0]   req_hec;
  logic [NREQ-1:0]     req_chk;
  logic [NREQ-1:0]     req_ready;
  logic [31:0]         hec_in;
  logic [7:0]          hec_out;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [7:0]          rsp_hec;
  logic                rsp_err;
  logic [15:0]         err_cnt;

  hec_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_hdr(req_hdr), .req_hec(req_hec), .req_chk(req_chk),
    .req_ready(req_ready), .hec_in(hec_in), .hec_out(hec_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_hec(rsp_hec), .rsp_err(rsp_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // CRC-8 (x^8+x^2+x+1), header MSB first, zero init, coset 0x55.
  function automatic logic [7:0] hec_of(input logic [31:0] h);
    logic [7:0] c;
    logic fb;
    c = 8'h00;
    for (int i = 31; i >= 0; i--) begin
      fb = c[7] ^ h[i];
      c  = {c[6:0], 1'b0};
      if (fb) c = c ^ 8'h07;
    end
    return c ^ 8'h55;
  endfunction

  assign hec_out = hec_of(hec_in);

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    int         id;
    logic [7:0] hec;
    logic       err;
  } exp_t;
  exp_t sb[$];

  // Reference model: response slot occupancy, last grant position, error tally.
  bit m_full = 0;
  int m_ptr = 0;
  int m_cnt = 0;

  always @(negedge clk) begin
    int g;
    exp_t e;
    #3;
    if (!rst_n) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_hec_in", hec_in, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_err_cnt", err_cnt, 0);
      m_full = 0; m_ptr = 0; m_cnt = 0;
      sb.delete();
    end else begin
      chk("rsp_valid", rsp_valid, m_full);
      chk("err_cnt", err_cnt, m_cnt);
      g = -1;
      if (!m_full || rsp_ready)
        for (int k = 0; k < NREQ; k++)
          if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
      chk("req_ready", req_ready, (g >= 0) ? (32'd1 << g) : 32'd0);
      chk("hec_in", hec_in, (g >= 0) ? req_hdr[32*g +: 32] : 32'd0);
      if (g >= 0) begin
        e.id  = g;
        e.hec = hec_of(req_hdr[32*g +: 32]);
        e.err = req_chk[g] && (e.hec != req_hec[8*g +: 8]);
        sb.push_back(e);
        m_ptr  = (g + 1) % NREQ;
        m_full = 1;
        if (e.err && m_cnt < 65535) m_cnt++;
      end else if (rsp_ready) begin
        m_full = 0;
      end
    end
  end

  // Monitor: compares the presented response with the oldest expected entry; pops on handshake.
  always @(negedge clk) begin
    #3;
    if (rst_n && rsp_valid) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        chk("rsp_id", rsp_id, sb[0].id);
        chk("rsp_hec", rsp_hec, sb[0].hec);
        chk("rsp_err", rsp_err, sb[0].err);
        if (rsp_ready) void'(sb.pop_front());
      end
    end
  end

  // Driver state: a request stays posted until accepted.
  bit          pv [NREQ];
  logic [31:0] ph [NREQ];
  logic [7:0]  pe [NREQ];
  bit          pc [NREQ];

  task automatic post(input int i, input logic [31:0] h, input logic [7:0] e, input bit c);
    pv[i] = 1; ph[i] = h; pe[i] = e; pc[i] = c;
  endtask

  task automatic step();
    logic [NREQ-1:0] acc;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]        = pv[i];
      req_hdr[32*i +: 32] = ph[i];
      req_hec[8*i +: 8]   = pe[i];
      req_chk[i]          = pc[i];
    end
    #4;
    acc = req_valid & req_ready;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) if (acc[i]) pv[i] = 0;
  endtask

  initial begin
    logic [31:0] h;
    for (int i = 0; i < NREQ; i++) begin pv[i] = 0; ph[i] = 0; pe[i] = 0; pc[i] = 0; end
    rst_n = 0; rsp_ready = 0;
    req_valid = '0; req_hdr = '0; req_hec = '0; req_chk = '0;
    @(negedge clk);
    step(); step();
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_rsp_hec", rsp_hec, 0);
    rst_n = 1; rsp_ready = 1;

    // Generate mode on requester 0.
    post(0, 32'h0, 8'h00, 0);
    step();
    chk("gen_valid", rsp_valid, 1);
    chk("gen_id", rsp_id, 0);
    chk("gen_hec", rsp_hec, 8'h55);
    chk("gen_err", rsp_err, 0);
    chk("gen_cnt", err_cnt, 0);

    // Check mode on requester 2: match then mismatch.
    post(2, 32'h1, 8'h52, 1);
    step();
    chk("chk_hec", rsp_hec, 8'h52);
    chk("chk_err0", rsp_err, 0);
    post(2, 32'h1, 8'h53, 1);
    step();
    chk("chk_err1", rsp_err, 1);
    chk("chk_cnt1", err_cnt, 1);

    // Bring pointer to 0, then all four requesters valid for 8 cycles.
    post(3, 32'hCAFE_F00D, 8'h00, 0);
    step();
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < NREQ; i++) if (!pv[i]) post(i, $urandom, 8'h00, 0);
      step();
      chk("rr_valid", rsp_valid, 1);
      chk("rr_id", rsp_id, c % NREQ);
    end
    for (int i = 0; i < NREQ; i++) pv[i] = 0;

    // Back-pressure with requesters 1 and 3 pending; last grant was 3.
    rsp_ready = 0;
    post(1, 32'h1111_1111, 8'h00, 0);
    post(3, 32'h3333_3333, 8'h00, 0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("bp_id", rsp_id, 3);
      chk("bp_pend", {30'd0, pv[3], pv[1]}, 2'b11);
    end
    rsp_ready = 1;
    step();
    chk("bp_next", rsp_id, 1);
    step();
    chk("bp_next2", rsp_id, 3);

    // Random traffic with random back-pressure.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!pv[i] && ($urandom_range(0, 99) < 45)) begin
          h = $urandom;
          post(i, h, ($urandom_range(0, 1) != 0) ? hec_of(h) : 8'($urandom), bit'($urandom_range(0, 1)));
        end
      rsp_ready = ($urandom_range(0, 99) < 70);
      step();
    end

    // Drain, then saturate the error counter from requester 0.
    for (int i = 0; i < NREQ; i++) pv[i] = 0;
    rsp_ready = 1;
    step(); step();
    for (int c = 0; c < 65540; c++) begin
      h = $urandom;
      post(0, h, hec_of(h) ^ 8'h01, 1);
      step();
    end
    chk("sat_cnt", err_cnt, 16'hFFFF);

    // Reset mid-stream with a response held.
    chk("pre_rst_valid", rsp_valid, 1);
    pv[0] = 0;
    post(1, 32'hABCD_0001, 8'h00, 0);
    post(3, 32'hABCD_0003, 8'h00, 0);
    rst_n = 0;
    #1;
    chk("rst_valid_now", rsp_valid, 0);
    chk("rst_cnt_now", err_cnt, 0);
    @(negedge clk);
    step();
    rst_n = 1;
    step();
    chk("post_rst_id", rsp_id, 1);
    for (int i = 0; i < NREQ; i++) pv[i] = 0;
    for (int c = 0; c < 4; c++) step();
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
